stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Control FSM that sequences the 4-digit cascaded BCD counter chain as a start/stop/lap/clear stopwatch.
- Debounces three active-low push buttons and generates a single-cycle count-enable tick from the 50 MHz clock.
- Drives the chain's clear and exposes a frozen-or-live 16-bit BCD value to the seven-segment decoders.
- Sits between the KEY inputs and the counter chain/display decoders in top-level integration.

Parameters:
- TICK_DIV, 5000000, CLOCK_50 cycles per count tick (5000000 gives 10 Hz, tenths of a second); legal range ≥2.
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronized cycles needed to accept a new button level (10 ms); legal range ≥1.

Ports:
- iClk  in  1  system clock (CLOCK_50).
- iRst  in  1  synchronous, active-high reset.
- iStartStop_n  in  1  start/stop button, active-low, asynchronous to iClk.
- iLap_n  in  1  lap button, active-low, asynchronous.
- iClear_n  in  1  clear button, active-low, asynchronous.
- iDigits  in  16  live BCD from the counter chain; [15:12] is the most significant digit, [3:0] the least.
- oCountEn  out  1  one-cycle tick to the least significant counter stage.
- oClear  out  1  one-cycle clear pulse to the counter chain.
- oDisplay  out  16  BCD value to the display decoders.
- oState  out  2  FSM state: IDLE=00, RUN=01, PAUSE=10, LAP=11.

Behaviour:
- Reset (iRst=1 at a rising edge):
  - State goes to IDLE; prescaler, debounce counters and lap register clear to 0; debounced button levels set to 1 (released).
  - oCountEn=0, oClear=0, oDisplay=16'h0000.
  - Reset overrides every pending event. No oClear pulse is generated by reset itself.
- Button front end, per button:
  - 2-FF synchronizer feeds a debouncer.
  - Debouncer counter increments while the synchronized level differs from the accepted level. It resets to 0 on any agreement (bounce).
  - When the counter reaches DEBOUNCE_CYCLES, the accepted level flips and the counter resets.
  - Accepted 1→0 transition produces a one-cycle press event. Release produces no event.
- Event priority:
  - Order is clear > start/stop > lap.
  - At most one event acts per cycle; lower-priority events in the same cycle are dropped.
  - Events not legal in the current state are ignored.
- FSM transitions, applied at the edge after the event pulse:
  - IDLE: start → RUN. clear → pulse oClear, stay in IDLE. lap ignored.
  - RUN: start → PAUSE. lap → LAP, and the lap register captures iDigits in the same edge. clear ignored.
  - LAP: start → PAUSE. lap → RUN, display returns to live. clear ignored.
  - PAUSE: start → RUN. clear → pulse oClear, reset prescaler to 0, go to IDLE. lap ignored.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN or LAP; holds its value in PAUSE so a resume is exact.
  - oCountEn is registered and high for exactly the cycle after the prescaler value is TICK_DIV-1; the prescaler wraps to 0 on that edge.
  - First tick after IDLE→RUN occurs exactly TICK_DIV cycles after oState shows RUN.
  - No tick is issued in IDLE or PAUSE, including a wrap in progress on the PAUSE entry edge.
- oClear:
  - Registered; asserted for one cycle on the edge that takes the clear transition.
  - Never asserted in the same cycle as oCountEn.
- oDisplay:
  - Registered, one-cycle latency.
  - Shows the lap register in LAP, otherwise iDigits.
  - Entering PAUSE from LAP releases the freeze.
- The controller does not inspect iDigits except for the lap capture and the optional feature. Chain wrap from 9999 to 0000 is the chain's own behaviour.

Optional Feature:
- Macro: STOPWATCH_CTRL_OVF_STOP_EN.
- Defined: when a tick is due while iDigits==16'h9999, oCountEn is suppressed, the prescaler resets to 0, and state goes to PAUSE. The display holds 9999.
- Undefined: ticks are issued unconditionally and the chain wraps to 0000.

Test Plan (TICK_DIV=4, DEBOUNCE_CYCLES=3):
- Reset then hold start low for 10 cycles → oState=01 within DEBOUNCE_CYCLES+4 cycles; oCountEn pulses every 4 cycles, each pulse exactly 1 cycle wide.
- Start button bouncing low/high every 2 cycles for 20 cycles, then high → no event, oState stays 00.
- In RUN, press lap while iDigits=16'h0123, then change iDigits to 16'h0456 → oDisplay holds 0123, oState=11, ticks continue; press lap again → oDisplay=0456, oState=01.
- Press start in RUN with prescaler=2, wait 50 cycles, press start → oState toggles 01→10→01, no ticks during PAUSE, next tick 2 cycles after resume; then in PAUSE press clear → one-cycle oClear, oState=00.
- Press clear and start in the same cycle while in PAUSE → only clear acts: oClear=1 for 1 cycle, oState=00. Assert iRst mid-RUN → next cycle oState=00, oCountEn=0, oDisplay=0000.
- With STOPWATCH_CTRL_OVF_STOP_EN defined, iDigits=16'h9999 in RUN → no oCountEn at the due tick, oState=10; with the macro undefined → tick issued normally.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: start/stop/lap/clear sequencer for a 4-digit BCD counter chain.
// Define STOPWATCH_CTRL_OVF_STOP_EN to pause at 9999 instead of wrapping.
module stopwatch_ctrl #(
   parameter int TICK_DIV        = 5000000,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic        iClk,
   input  logic        iRst,
   input  logic        iStartStop_n,
   input  logic        iLap_n,
   input  logic        iClear_n,
   input  logic [15:0] iDigits,
   output logic        oCountEn,
   output logic        oClear,
   output logic [15:0] oDisplay,
   output logic [1:0]  oState
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, LAP = 2'b11} state_t;
   state_t             state, nstate;
   logic [2:0]         btn, acc, ev;
   logic [2:0][1:0]    sync;
   logic [2:0][DW-1:0] cnt;
   logic [PW-1:0]      pre, pre_nx;
   logic [15:0]        lap_q, lap_nx, disp_nx;
   logic               clr_ev, ss_ev, lap_ev, active, due, ovf, clr_nx, cen_nx;

   assign btn = {iClear_n, iStartStop_n, iLap_n};

   // bit 2 clear, bit 1 start/stop, bit 0 lap; ev pulses on an accepted press
   always_ff @(posedge iClk)
      if (iRst) begin
         sync <= '1;
         acc  <= '1;
         cnt  <= '0;
         ev   <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            sync[i] <= {sync[i][0], btn[i]};
            ev[i]   <= 1'b0;
            if (sync[i][1] == acc[i])
               cnt[i] <= '0;
            else if (cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
               cnt[i] <= '0;
               acc[i] <= ~acc[i];
               ev[i]  <= acc[i];
            end else
               cnt[i] <= cnt[i] + 1'b1;
         end
      end

   assign clr_ev = ev[2];
   assign ss_ev  = ev[1] & ~ev[2];
   assign lap_ev = ev[0] & ~|ev[2:1];
   assign active = state == RUN || state == LAP;
   assign due    = active && pre == PW'(TICK_DIV - 1);
`ifdef STOPWATCH_CTRL_OVF_STOP_EN
   assign ovf = due && iDigits == 16'h9999;
`else
   assign ovf = 1'b0;
`endif

   always_ff @(posedge iClk)
      if (iRst) begin
         state    <= IDLE;
         pre      <= '0;
         lap_q    <= '0;
         oCountEn <= 1'b0;
         oClear   <= 1'b0;
         oDisplay <= '0;
      end else begin
         state    <= nstate;
         pre      <= pre_nx;
         lap_q    <= lap_nx;
         oCountEn <= cen_nx;
         oClear   <= clr_nx;
         oDisplay <= disp_nx;
      end

   always_comb begin
      nstate = state;
      unique case (state)
         IDLE:  nstate = ss_ev ? RUN : IDLE;
         RUN:   nstate = ss_ev ? PAUSE : lap_ev ? LAP : RUN;
         LAP:   nstate = ss_ev ? PAUSE : lap_ev ? RUN : LAP;
         PAUSE: nstate = clr_ev ? IDLE : ss_ev ? RUN : PAUSE;
      endcase
      if (ovf)
         nstate = PAUSE;
   end

   // a wrap on the edge that leaves RUN/LAP is swallowed rather than ticked
   always_comb begin
      clr_nx  = clr_ev && (state == IDLE || state == PAUSE);
      cen_nx  = due && !ovf && (nstate == RUN || nstate == LAP);
      pre_nx  = (clr_nx || ovf) ? '0 : !active ? pre : due ? '0 : pre + 1'b1;
      lap_nx  = (state == RUN && lap_ev) ? iDigits : lap_q;
      disp_nx = (state == LAP) ? lap_q : iDigits;
   end

   assign oState = state;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: vector table plus scoreboard and timing sequences for stopwatch_ctrl.
module tb_stopwatch_ctrl;
   localparam int TD = 4, DB = 3;
   logic        clk = 0, rst = 1, ss_n = 1, lap_n = 1, clr_n = 1;
   logic [15:0] dig = 0, disp;
   logic        cen, clr;
   logic [1:0]  st;
   int          errors = 0, checks = 0, tick_cnt = 0, clr_cnt = 0, width_bad = 0, both_bad = 0;
   logic        cen_prev = 0, clr_prev = 0;

   typedef struct {
      logic [2:0]  btn;
      logic [15:0] dig;
      logic [1:0]  st;
      logic [15:0] disp;
      int          clrs;
      int          ticks;
   } vec_t;
   vec_t tbl[17];
   vec_t sb[$];

   stopwatch_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
      .iClk(clk), .iRst(rst), .iStartStop_n(ss_n), .iLap_n(lap_n), .iClear_n(clr_n),
      .iDigits(dig), .oCountEn(cen), .oClear(clr), .oDisplay(disp), .oState(st)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #2;
      if (rst) begin
         cen_prev <= 1'b0;
         clr_prev <= 1'b0;
      end else begin
         if (cen) tick_cnt <= tick_cnt + 1;
         if (clr) clr_cnt <= clr_cnt + 1;
         if ((cen && cen_prev) || (clr && clr_prev)) width_bad <= width_bad + 1;
         if (cen && clr) both_bad <= both_bad + 1;
         cen_prev <= cen;
         clr_prev <= clr;
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the end");
      $fatal(1);
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string nm, input logic ok, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      check(nm, got == exp, got, exp);
   endtask

   // m: bit 2 clear, bit 1 start/stop, bit 0 lap
   task automatic press(input logic [2:0] m);
      clr_n = ~m[2];
      ss_n  = ~m[1];
      lap_n = ~m[0];
      cyc(8);
      clr_n = 1;
      ss_n  = 1;
      lap_n = 1;
      cyc(10);
   endtask

   initial begin
      int   run_at, p, k, frozen, c0, c1, t0, nt;
      int   tk[$];
      logic found, got, done;
      vec_t e;
      tbl[0]  = '{3'b001, 16'h0123, 2'b11, 16'h0123, 0, 2};
      tbl[1]  = '{3'b000, 16'h0456, 2'b11, 16'h0123, 0, 2};
      tbl[2]  = '{3'b001, 16'h0456, 2'b01, 16'h0456, 0, 2};
      tbl[3]  = '{3'b001, 16'h0789, 2'b11, 16'h0789, 0, 2};
      tbl[4]  = '{3'b000, 16'h0999, 2'b11, 16'h0789, 0, 2};
      tbl[5]  = '{3'b010, 16'h0999, 2'b10, 16'h0999, 0, 0};
      tbl[6]  = '{3'b001, 16'h0999, 2'b10, 16'h0999, 0, 0};
      tbl[7]  = '{3'b010, 16'h1000, 2'b01, 16'h1000, 0, 2};
      tbl[8]  = '{3'b100, 16'h1001, 2'b01, 16'h1001, 0, 2};
      tbl[9]  = '{3'b010, 16'h1002, 2'b10, 16'h1002, 0, 0};
      tbl[10] = '{3'b100, 16'h0000, 2'b00, 16'h0000, 1, 0};
      tbl[11] = '{3'b001, 16'h0000, 2'b00, 16'h0000, 0, 0};
      tbl[12] = '{3'b100, 16'h0000, 2'b00, 16'h0000, 1, 0};
      tbl[13] = '{3'b011, 16'h0000, 2'b01, 16'h0000, 0, 2};
      tbl[14] = '{3'b010, 16'h0000, 2'b10, 16'h0000, 0, 0};
      tbl[15] = '{3'b110, 16'h0000, 2'b00, 16'h0000, 1, 0};
      tbl[16] = '{3'b010, 16'h0000, 2'b01, 16'h0000, 0, 2};

      dig = 16'h1234;
      cyc(3);
      chk("reset_state", st, 2'b00);
      chk("reset_counten", cen, 0);
      chk("reset_clear", clr, 0);
      chk("reset_display", disp, 16'h0000);
      rst = 0;
      dig = 0;
      cyc(2);

      t0 = tick_cnt;
      for (int i = 0; i < 20; i++) begin
         ss_n = ((i / 2) % 2) == 1;
         cyc(1);
      end
      ss_n = 1;
      cyc(20);
      chk("bounce_state", st, 2'b00);
      chk("bounce_ticks", tick_cnt - t0, 0);

      run_at = -1;
      ss_n = 0;
      for (int n = 1; n <= 30; n++) begin
         cyc(1);
         if (n == 10) ss_n = 1;
         if (st == 2'b01 && run_at < 0) run_at = n;
         if (cen) tk.push_back(n);
      end
      check("start_latency", run_at >= 1 && run_at <= DB + 4, run_at, DB + 4);
      chk("tick_count", tk.size(), (30 - run_at) / TD);
      if (tk.size() > 0) chk("first_tick", tk[0], run_at + TD);
      for (int i = 1; i < tk.size(); i++) chk($sformatf("tick_period%0d", i), tk[i] - tk[i-1], TD);
      cyc(10);

      for (int i = 0; i < 17; i++) begin
         dig = tbl[i].dig;
         c0 = clr_cnt;
         sb.push_back(tbl[i]);
         press(tbl[i].btn);
         c1 = clr_cnt - c0;
         t0 = tick_cnt;
         cyc(8);
         e = sb.pop_front();
         chk($sformatf("vec%0d_state", i), st, e.st);
         chk($sformatf("vec%0d_display", i), disp, e.disp);
         chk($sformatf("vec%0d_clears", i), c1, e.clrs);
         chk($sformatf("vec%0d_ticks", i), tick_cnt - t0, e.ticks);
      end

      found = 0;
      for (int n = 0; n < 12 && !found; n++) begin
         cyc(1);
         if (cen) found = 1;
      end
      chk("pause_sync", found, 1);
      ss_n = 0;
      p = 1;
      got = 0;
      for (int n = 1; n <= 20; n++) begin
         cyc(1);
         if (n == 8) ss_n = 1;
         if (!got) begin
            if (st == 2'b10) got = 1;
            else p++;
         end
      end
      chk("pause_enter", got, 1);
      frozen = p % TD;
      t0 = tick_cnt;
      cyc(50);
      chk("pause_ticks", tick_cnt - t0, 0);
      chk("pause_state", st, 2'b10);
      ss_n = 0;
      got = 0;
      done = 0;
      k = 0;
      nt = 0;
      for (int n = 1; n <= 30; n++) begin
         cyc(1);
         if (n == 8) ss_n = 1;
         if (!got) begin
            if (cen) nt++;
            if (st == 2'b01) got = 1;
         end else if (!done) begin
            k++;
            if (cen) done = 1;
         end
      end
      chk("resume_state", got, 1);
      chk("resume_no_early_tick", nt, 0);
      chk("resume_tick_seen", done, 1);
      chk("resume_tick_delay", k, frozen == 0 ? TD : TD - frozen);
      cyc(10);
      press(3'b010);
      chk("pause2_state", st, 2'b10);
      c0 = clr_cnt;
      press(3'b100);
      chk("pause_clear_pulses", clr_cnt - c0, 1);
      chk("pause_clear_state", st, 2'b00);

      press(3'b010);
      chk("prereset_state", st, 2'b01);
      dig = 16'h4321;
      cyc(2);
      rst = 1;
      cyc(1);
      chk("midrun_reset_state", st, 2'b00);
      chk("midrun_reset_counten", cen, 0);
      chk("midrun_reset_display", disp, 16'h0000);
      rst = 0;
      dig = 0;
      cyc(3);

      press(3'b010);
      chk("ovf_run_state", st, 2'b01);
      dig = 16'h9999;
      t0 = tick_cnt;
      cyc(12);
`ifdef STOPWATCH_CTRL_OVF_STOP_EN
      chk("ovf_ticks", tick_cnt - t0, 0);
      chk("ovf_state", st, 2'b10);
`else
      chk("ovf_ticks", tick_cnt - t0, 12 / TD);
      chk("ovf_state", st, 2'b01);
`endif
      chk("ovf_display", disp, 16'h9999);

      chk("pulse_width", width_bad, 0);
      chk("clear_with_tick", both_bad, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
